mc_control_fsm: RTL and testbench
=================================

// Module: mc_control_fsm
// PURPOSE
// - Main multi-cycle controller for the RV32I core in top.
// - Sequences fetch/decode/execute/memory/writeback over the shared unified memory, register file and ALU.
// - Drives every datapath enable and mux select; waits on a memory ready handshake; traps on illegal opcode or memory timeout.
// PARAMETERS
// - MEM_TIMEOUT  15  max consecutive cycles with mem_req=1 and mem_ready=0 before FAULT (0 = wait forever)
// PORTS
// - clk         in   1  system clock
// - reset       in   1  synchronous, active-low reset
// - opcode      in   7  instr[6:0] from instruction register
// - cond_met    in   1  branch comparator result
// - mem_ready   in   1  memory completes current access this cycle
// - mem_req     out  1  memory access request
// - mem_write   out  1  store strobe (valid only with mem_req)
// - adr_src     out  1  memory address: 0=PC, 1=ALUOut
// - ir_write    out  1  load instruction register and old_pc
// - pc_write    out  1  load PC from result mux
// - reg_write   out  1  register file write enable
// - alu_src_a   out  2  00=PC, 01=old_pc, 10=rs1, 11=zero
// - alu_src_b   out  2  00=rs2, 01=imm, 10=const 4
// - alu_op      out  2  00=add, 01=sub, 10=funct-decoded
// - result_src  out  2  00=ALUOut, 01=mem read data, 10=ALU result
// - imm_src     out  3  000 I, 001 S, 010 B, 011 J, 100 U (combinational from opcode in all states)
// - fault       out  1  sticky trap flag
// - state_dbg   out  4  current state encoding
// BEHAVIOUR
// - Outputs are combinational from state; ir_write/pc_write in FETCH also gated by mem_ready.
// - Unlisted outputs are 0 in every state.
// - reset=0 at edge: state<=FETCH, wait counter<=0, fault<=0.
// - While reset=0, mem_req, mem_write and all *_write enables are forced 0 combinationally.
//   A reset during any wait aborts the access; no store is committed.
// - FETCH: mem_req, adr_src=0. Holds until mem_ready.
//   On mem_ready: ir_write, pc_write, a=00, b=10, add, result_src=10 -> DECODE.
// - DECODE: a=01, b=01, add (branch/jal target into ALUOut). Next state by opcode:
//   0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH;
//   1101111 -> JAL; 1100111 -> JALR; 0110111/0010111 -> UPPER; any other -> FAULT.
// - MEMADR: a=10, b=01, add. Load -> MEMREAD; store -> MEMWRITE.
// - MEMREAD: mem_req, adr_src=1. Holds until mem_ready, then -> MEMWB.
// - MEMWB: result_src=01, reg_write -> FETCH.
// - MEMWRITE: mem_req, mem_write, adr_src=1, all held stable while waiting. On mem_ready -> FETCH.
// - EXECR: a=10, b=00, alu_op=10 -> ALUWB.
// - EXECI: a=10, b=01, alu_op=10 -> ALUWB.
// - ALUWB: result_src=00, reg_write -> FETCH.
// - BRANCH: a=10, b=00, sub, result_src=00, pc_write=cond_met -> FETCH.
// - JALR: a=10, b=01, add (target into ALUOut) -> JAL.
// - JAL: result_src=00, pc_write; a=01, b=10, add (old_pc+4 into ALUOut) -> ALUWB.
// - UPPER: b=01, add; a=11 for LUI (0110111), a=01 for AUIPC -> ALUWB.
// - FAULT: fault=1, all enables 0. Absorbing; exits only on reset.
// - Wait counter ($clog2(MEM_TIMEOUT+1) bits):
//   +1 per cycle with mem_req & !mem_ready; cleared on mem_ready or any state change.
//   Count == MEM_TIMEOUT with mem_ready=0 -> FAULT. Same-cycle mem_ready wins and the access completes.
// - Latency at mem_ready=1: R/I 4, load 5, store 4, branch 3, jal 4, jalr 5, lui/auipc 4 cycles.
// STRUCTURE
// - Package riscv_ctrl_pkg: state_t enum (4-bit), opcode localparams, mux/alu_op/imm_src encodings.
// - Sub-module mem_wait_timer: wait counter plus timeout flag.
// - Next-state logic and output decode live in this module.
// TESTING
// - Reset 2 cycles, mem_ready=1, opcode 0100011 -> FETCH,DECODE,MEMADR,MEMWRITE,FETCH; mem_write high exactly 1 cycle with adr_src=1.
// - Opcode 0000011, mem_ready=0 for 3 cycles in MEMREAD -> mem_req held 4 cycles; reg_write only in MEMWB with result_src=01.
// - Opcode 1100011: cond_met=0 -> pc_write=0 in BRANCH; cond_met=1 -> pc_write=1, result_src=00.
// - Opcode 1100111 -> DECODE,JALR,JAL,ALUWB; pc_write in JAL only, reg_write in ALUWB only.
// - MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH -> FAULT after 4 wait cycles, fault sticky until reset.
//   Opcode 0000000 -> FAULT from DECODE.
// - reset=0 during MEMWRITE wait -> mem_req/mem_write 0 same cycle, state_dbg=FETCH after edge.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: state enum, opcodes,
// datapath mux selects and the immediate-format decode.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_UPPER    = 4'd12,
    S_FAULT    = 4'd13
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  function automatic logic [2:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_STORE:          return IMM_S;
      OP_BRANCH:         return IMM_B;
      OP_JAL:            return IMM_J;
      OP_LUI, OP_AUIPC:  return IMM_U;
      default:           return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Controller <-> datapath/memory bundle. master = controller, slave = datapath side.
interface mc_control_fsm_if;
  logic [6:0] opcode;
  logic       cond_met;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_write;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] result_src;
  logic [2:0] imm_src;
  logic       fault;
  logic [3:0] state_dbg;

  modport master (
    input  opcode, cond_met, mem_ready,
    output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, alu_op, result_src, imm_src, fault, state_dbg
  );

  modport slave (
    output opcode, cond_met, mem_ready,
    input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, alu_op, result_src, imm_src, fault, state_dbg
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts stalled memory-request cycles; flags a timeout when the count reaches
// MEM_TIMEOUT while the access is still pending (MEM_TIMEOUT=0 disables it).
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic mem_req,
  input  logic mem_ready,
  input  logic clr,
  output logic timeout
);
  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset)                 cnt <= '0;
    else if (clr || mem_ready)  cnt <= '0;
    else if (mem_req)           cnt <= cnt + CW'(1);
  end

  // mem_ready in the same cycle overrides the timeout so the access completes
  assign timeout = (MEM_TIMEOUT != 0) && mem_req && !mem_ready &&
                   (cnt == CW'(MEM_TIMEOUT));
endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I controller: sequences fetch/decode/execute/memory/writeback
// and drives every datapath enable and mux select from the current state.
module mc_control_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  mc_control_fsm_if.master bus
);
  state_t     state, state_nxt;
  logic       timeout;
  logic       req, wr, asrc, irw, pcw, rgw;
  logic [1:0] sa, sb, aop, rsrc;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .mem_req   (req),
    .mem_ready (bus.mem_ready),
    .clr       (state_nxt != state),
    .timeout   (timeout)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:    if (bus.mem_ready) state_nxt = S_DECODE;
                  else if (timeout)  state_nxt = S_FAULT;
      S_DECODE:
        case (bus.opcode)
          OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
          OP_R:              state_nxt = S_EXECR;
          OP_I:              state_nxt = S_EXECI;
          OP_BRANCH:         state_nxt = S_BRANCH;
          OP_JAL:            state_nxt = S_JAL;
          OP_JALR:           state_nxt = S_JALR;
          OP_LUI, OP_AUIPC:  state_nxt = S_UPPER;
          default:           state_nxt = S_FAULT;
        endcase
      S_MEMADR:   state_nxt = (bus.opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (bus.mem_ready) state_nxt = S_MEMWB;
                  else if (timeout)  state_nxt = S_FAULT;
      S_MEMWRITE: if (bus.mem_ready) state_nxt = S_FETCH;
                  else if (timeout)  state_nxt = S_FAULT;
      S_MEMWB, S_ALUWB, S_BRANCH:  state_nxt = S_FETCH;
      S_EXECR, S_EXECI, S_UPPER:   state_nxt = S_ALUWB;
      S_JALR:     state_nxt = S_JAL;
      S_JAL:      state_nxt = S_ALUWB;
      S_FAULT:    state_nxt = S_FAULT;
      default:    state_nxt = S_FAULT;
    endcase
  end

  always_comb begin
    req  = 1'b0;  wr  = 1'b0;  asrc = 1'b0;
    irw  = 1'b0;  pcw = 1'b0;  rgw  = 1'b0;
    sa   = SRCA_PC;  sb = SRCB_RS2;  aop = ALU_ADD;  rsrc = RES_ALUOUT;
    case (state)
      S_FETCH: begin
        req = 1'b1;  irw = bus.mem_ready;  pcw = bus.mem_ready;
        sb  = SRCB_FOUR;  rsrc = RES_ALU;
      end
      S_DECODE:          begin sa = SRCA_OLDPC; sb = SRCB_IMM; end
      S_MEMADR, S_JALR:  begin sa = SRCA_RS1;   sb = SRCB_IMM; end
      S_MEMREAD:         begin req = 1'b1; asrc = 1'b1; end
      S_MEMWB:           begin rsrc = RES_MEM; rgw = 1'b1; end
      S_MEMWRITE:        begin req = 1'b1; wr = 1'b1; asrc = 1'b1; end
      S_EXECR:           begin sa = SRCA_RS1; sb = SRCB_RS2; aop = ALU_FUNCT; end
      S_EXECI:           begin sa = SRCA_RS1; sb = SRCB_IMM; aop = ALU_FUNCT; end
      S_ALUWB:           rgw = 1'b1;
      S_BRANCH: begin
        sa = SRCA_RS1;  sb = SRCB_RS2;  aop = ALU_SUB;  pcw = bus.cond_met;
      end
      S_JAL:             begin pcw = 1'b1; sa = SRCA_OLDPC; sb = SRCB_FOUR; end
      S_UPPER: begin
        sb = SRCB_IMM;
        sa = (bus.opcode == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
      end
      default: ;
    endcase
  end

  // Reset low kills any in-flight access in the same cycle so no store commits
  assign bus.mem_req    = req  & reset;
  assign bus.mem_write  = wr   & reset;
  assign bus.ir_write   = irw  & reset;
  assign bus.pc_write   = pcw  & reset;
  assign bus.reg_write  = rgw  & reset;
  assign bus.adr_src    = asrc;
  assign bus.alu_src_a  = sa;
  assign bus.alu_src_b  = sb;
  assign bus.alu_op     = aop;
  assign bus.result_src = rsrc;
  assign bus.imm_src    = imm_sel(bus.opcode);
  assign bus.fault      = (state == S_FAULT);
  assign bus.state_dbg  = state;
endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm (MEM_TIMEOUT=4): walks each instruction class
// and compares state plus the packed control word against hand-derived values.
module tb_mc_control_fsm;
  import riscv_ctrl_pkg::*;

  // {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, a, b, alu_op, result_src}
  localparam logic [13:0] C_FETCH_RDY  = 14'b100110_00_10_00_10;
  localparam logic [13:0] C_FETCH_WAIT = 14'b100000_00_10_00_10;
  localparam logic [13:0] C_FETCH_RST  = 14'b000000_00_10_00_10;
  localparam logic [13:0] C_DECODE     = 14'b000000_01_01_00_00;
  localparam logic [13:0] C_MEMADR     = 14'b000000_10_01_00_00;
  localparam logic [13:0] C_MEMWR      = 14'b111000_00_00_00_00;
  localparam logic [13:0] C_MEMRD      = 14'b101000_00_00_00_00;
  localparam logic [13:0] C_MEMWB      = 14'b000001_00_00_00_01;
  localparam logic [13:0] C_EXECR      = 14'b000000_10_00_10_00;
  localparam logic [13:0] C_EXECI      = 14'b000000_10_01_10_00;
  localparam logic [13:0] C_ALUWB      = 14'b000001_00_00_00_00;
  localparam logic [13:0] C_BR0        = 14'b000000_10_00_01_00;
  localparam logic [13:0] C_BR1        = 14'b000010_10_00_01_00;
  localparam logic [13:0] C_JALR       = 14'b000000_10_01_00_00;
  localparam logic [13:0] C_JAL        = 14'b000010_01_10_00_00;
  localparam logic [13:0] C_LUI        = 14'b000000_11_01_00_00;
  localparam logic [13:0] C_AUIPC      = 14'b000000_01_01_00_00;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  mc_control_fsm_if bus ();

  mc_control_fsm #(.MEM_TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [13:0] ctl;
  assign ctl = {bus.mem_req, bus.mem_write, bus.adr_src, bus.ir_write, bus.pc_write,
                bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.result_src};

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; bus.opcode = OP_STORE; bus.mem_ready = 1'b1; bus.cond_met = 1'b0;
    tick(); tick(); #1;
    checks++;
    if (bus.state_dbg !== 4'(S_FETCH) || bus.fault !== 1'b0) begin
      errors++; $display("FAIL reset_state got %0d/%b want 0/0", bus.state_dbg, bus.fault);
    end
    checks++;
    if (ctl !== C_FETCH_RST) begin
      errors++; $display("FAIL reset_gating ctl %b want %b", ctl, C_FETCH_RST);
    end
    reset = 1'b1; #1;
    checks++;
    if (ctl !== C_FETCH_RDY) begin
      errors++; $display("FAIL fetch_ready ctl %b want %b", ctl, C_FETCH_RDY);
    end
  endtask

  task automatic test_store;
    state_t es[5];
    logic [13:0] ec[5];
    int nw = 0;
    es = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMWRITE, S_FETCH};
    ec = '{C_FETCH_RDY, C_DECODE, C_MEMADR, C_MEMWR, C_FETCH_RDY};
    bus.opcode = OP_STORE; bus.mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (bus.state_dbg !== 4'(es[i]) || ctl !== ec[i]) begin
        errors++;
        $display("FAIL store step %0d state %0d ctl %b want %0d %b", i, bus.state_dbg, ctl, es[i], ec[i]);
      end
      if (bus.mem_write && bus.adr_src) nw++;
      if (i < 4) tick();
    end
    checks++;
    if (nw !== 1) begin errors++; $display("FAIL store_write_cycles got %0d want 1", nw); end
    checks++;
    if (bus.imm_src !== 3'b001) begin errors++; $display("FAIL store_imm got %b want 001", bus.imm_src); end
  endtask

  task automatic test_load;
    state_t es[9];
    logic [13:0] ec[9];
    logic rdy[9];
    int nreq = 0, nrw = 0;
    es  = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMREAD, S_MEMREAD, S_MEMREAD, S_MEMWB, S_FETCH};
    ec  = '{C_FETCH_RDY, C_DECODE, C_MEMADR, C_MEMRD, C_MEMRD, C_MEMRD, C_MEMRD, C_MEMWB, C_FETCH_RDY};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    bus.opcode = OP_LOAD;
    for (int i = 0; i < 9; i++) begin
      bus.mem_ready = rdy[i];
      #1;
      checks++;
      if (bus.state_dbg !== 4'(es[i]) || ctl !== ec[i]) begin
        errors++;
        $display("FAIL load step %0d state %0d ctl %b want %0d %b", i, bus.state_dbg, ctl, es[i], ec[i]);
      end
      if (i > 0 && i < 8 && bus.mem_req) nreq++;
      if (bus.reg_write) nrw++;
      if (i < 8) tick();
    end
    checks++;
    if (nreq !== 4 || nrw !== 1) begin
      errors++; $display("FAIL load_counts req %0d rw %0d want 4 1", nreq, nrw);
    end
  endtask

  task automatic test_branch;
    state_t es[4];
    logic [13:0] ec[4];
    es = '{S_FETCH, S_DECODE, S_BRANCH, S_FETCH};
    bus.opcode = OP_BRANCH; bus.mem_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      bus.cond_met = c[0];
      ec = '{C_FETCH_RDY, C_DECODE, (c == 1) ? C_BR1 : C_BR0, C_FETCH_RDY};
      for (int i = 0; i < 4; i++) begin
        #1;
        checks++;
        if (bus.state_dbg !== 4'(es[i]) || ctl !== ec[i]) begin
          errors++;
          $display("FAIL branch c%0d step %0d state %0d ctl %b want %0d %b", c, i, bus.state_dbg, ctl, es[i], ec[i]);
        end
        if (i < 3) tick();
      end
    end
    checks++;
    if (bus.imm_src !== 3'b010) begin errors++; $display("FAIL branch_imm got %b want 010", bus.imm_src); end
    bus.cond_met = 1'b0;
  endtask

  task automatic test_jalr;
    state_t es[6];
    logic [13:0] ec[6];
    int npc = 0;
    es = '{S_FETCH, S_DECODE, S_JALR, S_JAL, S_ALUWB, S_FETCH};
    ec = '{C_FETCH_RDY, C_DECODE, C_JALR, C_JAL, C_ALUWB, C_FETCH_RDY};
    bus.opcode = OP_JALR; bus.mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (bus.state_dbg !== 4'(es[i]) || ctl !== ec[i]) begin
        errors++;
        $display("FAIL jalr step %0d state %0d ctl %b want %0d %b", i, bus.state_dbg, ctl, es[i], ec[i]);
      end
      if (i > 0 && i < 5 && bus.pc_write) npc++;
      if (i < 5) tick();
    end
    checks++;
    if (npc !== 1) begin errors++; $display("FAIL jalr_pc_writes got %0d want 1", npc); end
  endtask

  task automatic test_alu_upper;
    logic [6:0]  ops[4];
    state_t      mid[4];
    logic [13:0] mc[4];
    logic [2:0]  imm[4];
    state_t      es[5];
    logic [13:0] ec[5];
    ops = '{OP_R, OP_I, OP_LUI, OP_AUIPC};
    mid = '{S_EXECR, S_EXECI, S_UPPER, S_UPPER};
    mc  = '{C_EXECR, C_EXECI, C_LUI, C_AUIPC};
    imm = '{3'b000, 3'b000, 3'b100, 3'b100};
    bus.mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.opcode = ops[k];
      es = '{S_FETCH, S_DECODE, mid[k], S_ALUWB, S_FETCH};
      ec = '{C_FETCH_RDY, C_DECODE, mc[k], C_ALUWB, C_FETCH_RDY};
      for (int i = 0; i < 5; i++) begin
        #1;
        checks++;
        if (bus.state_dbg !== 4'(es[i]) || ctl !== ec[i]) begin
          errors++;
          $display("FAIL alu op%0d step %0d state %0d ctl %b want %0d %b", k, i, bus.state_dbg, ctl, es[i], ec[i]);
        end
        if (i < 4) tick();
      end
      checks++;
      if (bus.imm_src !== imm[k]) begin
        errors++; $display("FAIL alu_imm op%0d got %b want %b", k, bus.imm_src, imm[k]);
      end
    end
  endtask

  task automatic test_reset_abort;
    bus.opcode = OP_STORE; bus.mem_ready = 1'b1;
    tick(); tick(); tick();
    bus.mem_ready = 1'b0; #1;
    checks++;
    if (bus.state_dbg !== 4'(S_MEMWRITE) || ctl !== C_MEMWR) begin
      errors++; $display("FAIL abort_wait state %0d ctl %b want 5 %b", bus.state_dbg, ctl, C_MEMWR);
    end
    tick();
    reset = 1'b0; #1;
    checks++;
    if (bus.mem_req !== 1'b0 || bus.mem_write !== 1'b0 || bus.state_dbg !== 4'(S_MEMWRITE)) begin
      errors++;
      $display("FAIL abort_gate req %b wr %b state %0d want 0 0 5", bus.mem_req, bus.mem_write, bus.state_dbg);
    end
    tick();
    checks++;
    if (bus.state_dbg !== 4'(S_FETCH)) begin
      errors++; $display("FAIL abort_state got %0d want 0", bus.state_dbg);
    end
    reset = 1'b1;
  endtask

  task automatic test_illegal;
    bus.opcode = 7'b0000000; bus.mem_ready = 1'b1;
    tick(); tick(); #1;
    checks++;
    if (bus.state_dbg !== 4'(S_FAULT) || bus.fault !== 1'b1 || ctl !== 14'd0) begin
      errors++;
      $display("FAIL illegal state %0d fault %b ctl %b want 13 1 0", bus.state_dbg, bus.fault, ctl);
    end
    reset = 1'b0; tick(); reset = 1'b1;
  endtask

  task automatic test_timeout;
    bus.opcode = OP_R; bus.mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (bus.state_dbg !== 4'(S_FETCH) || ctl !== C_FETCH_WAIT) begin
        errors++;
        $display("FAIL timeout_wait cyc %0d state %0d ctl %b want 0 %b", i, bus.state_dbg, ctl, C_FETCH_WAIT);
      end
      tick();
    end
    checks++;
    if (bus.state_dbg !== 4'(S_FAULT) || bus.fault !== 1'b1 || ctl !== 14'd0) begin
      errors++;
      $display("FAIL timeout_fault state %0d fault %b ctl %b want 13 1 0", bus.state_dbg, bus.fault, ctl);
    end
    bus.mem_ready = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (bus.state_dbg !== 4'(S_FAULT) || bus.fault !== 1'b1) begin
      errors++; $display("FAIL fault_sticky state %0d fault %b want 13 1", bus.state_dbg, bus.fault);
    end
    reset = 1'b0; tick(); reset = 1'b1; #1;
    checks++;
    if (bus.state_dbg !== 4'(S_FETCH) || bus.fault !== 1'b0) begin
      errors++; $display("FAIL fault_clear state %0d fault %b want 0 0", bus.state_dbg, bus.fault);
    end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_branch();
    test_jalr();
    test_alu_upper();
    test_reset_abort();
    test_illegal();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
